// File: rtl/fifo_read_packer.sv
// Packs DATA_WIDTH-wide FIFO entries into BEATS-lane output words, popping at up to one entry per cycle.
// A flush emits a partially assembled word with its lane count. Unused lanes of that word are zero.
`timescale 1ns/1ps
module fifo_read_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int BEATS       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_fifo_empty,
  input  logic [DATA_WIDTH-1:0]       i_fifo_read_data,
  output logic                        o_fifo_read_increment,
  input  logic                        i_flush,
  output logic [DATA_WIDTH*BEATS-1:0] o_out_data,
  output logic [$clog2(BEATS):0]      o_out_bytes,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [COUNT_WIDTH-1:0]      o_word_count,
  output logic                        o_flush_pending
);
  localparam int BW = $clog2(BEATS);
  localparam int NW = BW + 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  logic [BW-1:0]                        r_beat;
  logic [BEATS-2:0][DATA_WIDTH-1:0]     r_asm;
  logic [DATA_WIDTH*BEATS-1:0]          r_out_data;
  logic [NW-1:0]                        r_out_bytes;
  logic                                 r_out_valid;
  logic                                 r_flush_pending;
  logic [COUNT_WIDTH-1:0]               r_word_count;

  logic                                 w_free;
  logic                                 w_accept;
  logic                                 w_pop;
  logic                                 w_req;
  logic                                 w_full_load;
  logic                                 w_flush_done;
  logic                                 w_xfer;
  logic [NW-1:0]                        w_fill;
  logic [DATA_WIDTH*BEATS-1:0]          w_full_word;
  logic [DATA_WIDTH*BEATS-1:0]          w_part_word;

  // The last lane is only taken when the output register can accept the finished word.
  assign w_free       = !r_out_valid || i_out_ready;
  assign w_accept     = (r_beat < LAST) || w_free;
  assign w_pop        = !i_fifo_empty && w_accept;
  assign w_req        = i_flush || r_flush_pending;
  assign w_full_load  = w_pop && (r_beat == LAST);
  assign w_flush_done = w_req && w_free && !w_full_load;
  assign w_xfer       = r_out_valid && i_out_ready;
  assign w_fill       = NW'(r_beat) + NW'(w_pop);
  assign w_full_word  = {i_fifo_read_data, r_asm};

  // Partial word: assembled lanes below beat_count, the same-cycle pop at lane beat_count, zeros above.
  always_comb begin
    w_part_word = '0;
    for (int i = 0; i < BEATS - 1; i++) begin
      if (i < int'(r_beat)) w_part_word[i*DATA_WIDTH +: DATA_WIDTH] = r_asm[i];
    end
    for (int i = 0; i < BEATS; i++) begin
      if (w_pop && (i == int'(r_beat))) w_part_word[i*DATA_WIDTH +: DATA_WIDTH] = i_fifo_read_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_beat          <= '0;
      r_asm           <= '0;
      r_out_data      <= '0;
      r_out_bytes     <= '0;
      r_out_valid     <= 1'b0;
      r_flush_pending <= 1'b0;
      r_word_count    <= '0;
    end else begin
      if (w_full_load) begin
        r_out_data  <= w_full_word;
        r_out_bytes <= NW'(BEATS);
        r_out_valid <= 1'b1;
      end else if (w_flush_done && (w_fill != '0)) begin
        r_out_data  <= w_part_word;
        r_out_bytes <= w_fill;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (w_full_load || w_flush_done) begin
        r_beat <= '0;
      end else if (w_pop) begin
        r_asm[r_beat] <= i_fifo_read_data;
        r_beat        <= r_beat + 1'b1;
      end

      // A full-word load defers the flush, so pending survives until a later free cycle.
      if (w_flush_done)  r_flush_pending <= 1'b0;
      else if (w_req)    r_flush_pending <= 1'b1;

      if (w_xfer) r_word_count <= r_word_count + 1'b1;
    end
  end

  assign o_fifo_read_increment = w_pop;
  assign o_out_data            = r_out_data;
  assign o_out_bytes           = r_out_bytes;
  assign o_out_valid           = r_out_valid;
  assign o_word_count          = r_word_count;
  assign o_flush_pending       = r_flush_pending;
endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: FIFO model, popped-byte scoreboard, directed and randomized scenarios.
`timescale 1ns/1ps
module tb_fifo_read_packer;
  localparam int DW = 8;
  localparam int BT = 4;
  localparam int CW = 16;

  logic                 clk;
  logic                 rst;
  logic                 i_fifo_empty;
  logic [DW-1:0]        i_fifo_read_data;
  logic                 o_fifo_read_increment;
  logic                 i_flush;
  logic [DW*BT-1:0]     o_out_data;
  logic [$clog2(BT):0]  o_out_bytes;
  logic                 o_out_valid;
  logic                 i_out_ready;
  logic [CW-1:0]        o_word_count;
  logic                 o_flush_pending;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  int pop_cnt = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pop_q[$];
  logic [DW*BT-1:0] exp_w;
  bit   ok_n;
  int   n;

  fifo_read_packer #(.DATA_WIDTH(DW), .BEATS(BT), .COUNT_WIDTH(CW)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_read_data(i_fifo_read_data),
    .o_fifo_read_increment(o_fifo_read_increment),
    .i_flush(i_flush),
    .o_out_data(o_out_data),
    .o_out_bytes(o_out_bytes),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_word_count(o_word_count),
    .o_flush_pending(o_flush_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO head presented to the DUT, refreshed shortly after each falling edge.
  always begin
    @(negedge clk);
    #2;
    i_fifo_empty     = (fifo_q.size() == 0);
    i_fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // Scoreboard: every transferred word must be the next out_bytes popped bytes in order, upper lanes zero.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      total++;
      if (o_fifo_read_increment && i_fifo_empty) begin
        bad++;
        $display("FAIL pop_while_empty got=1 want=0");
      end
      if (o_out_valid && i_out_ready) begin
        n     = int'(o_out_bytes);
        exp_w = '0;
        ok_n  = (n >= 1) && (n <= BT) && (n <= pop_q.size());
        if (ok_n) for (int i = 0; i < n; i++) exp_w[i*DW +: DW] = pop_q.pop_front();
        total++;
        if (!ok_n || (o_out_data !== exp_w)) begin
          bad++;
          $display("FAIL word got=%h bytes=%0d want=%h queued=%0d", o_out_data, n, exp_w, pop_q.size());
        end
        xfers++;
      end
      if (o_fifo_read_increment && !i_fifo_empty && (fifo_q.size() != 0)) begin
        pop_q.push_back(fifo_q.pop_front());
        pop_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic test_reset();
    #1;
    total++; if (o_out_valid !== 1'b0)            begin bad++; $display("FAIL rst_valid got=%b want=0", o_out_valid); end
    total++; if (o_word_count !== '0)             begin bad++; $display("FAIL rst_wc got=%0d want=0", o_word_count); end
    total++; if (o_flush_pending !== 1'b0)        begin bad++; $display("FAIL rst_pend got=%b want=0", o_flush_pending); end
    total++; if (o_fifo_read_increment !== 1'b0)  begin bad++; $display("FAIL rst_inc got=%b want=0", o_fifo_read_increment); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    i_out_ready = 1'b1;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
    repeat (3) @(posedge clk);
    #1;
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", o_out_valid); end
    @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b1)         begin bad++; $display("FAIL basic_valid got=%b want=1", o_out_valid); end
    total++; if (o_out_data !== 32'h44332211)  begin bad++; $display("FAIL basic_data got=%h want=44332211", o_out_data); end
    total++; if (o_out_bytes !== 3'd4)         begin bad++; $display("FAIL basic_bytes got=%0d want=4", o_out_bytes); end
    @(posedge clk); #1;
    total++; if (o_word_count !== 16'd1)       begin bad++; $display("FAIL basic_wc got=%0d want=1", o_word_count); end
    total++; if (o_out_valid !== 1'b0)         begin bad++; $display("FAIL basic_clear got=%b want=0", o_out_valid); end
  endtask

  task automatic test_backpressure();
    int base;
    @(negedge clk);
    i_out_ready = 1'b0;
    base = pop_cnt;
    for (int b = 1; b <= 8; b++) fifo_q.push_back(8'(b));
    repeat (12) @(posedge clk);
    #1;
    total++; if (pop_cnt - base != 7)          begin bad++; $display("FAIL bp_pops got=%0d want=7", pop_cnt - base); end
    total++; if (o_fifo_read_increment !== 1'b0 || i_fifo_empty !== 1'b0)
      begin bad++; $display("FAIL bp_stall got=inc%b/empty%b want=inc0/empty0", o_fifo_read_increment, i_fifo_empty); end
    total++; if (o_out_data !== 32'h04030201)  begin bad++; $display("FAIL bp_hold got=%h want=04030201", o_out_data); end
    @(negedge clk);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b1 || o_out_data !== 32'h08070605)
      begin bad++; $display("FAIL bp_second got=%b/%h want=1/08070605", o_out_valid, o_out_data); end
    @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b0)         begin bad++; $display("FAIL bp_drain got=%b want=0", o_out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    i_out_ready = 1'b1;
    fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b1 || o_out_data !== 32'h0000BBAA)
      begin bad++; $display("FAIL flush_data got=%b/%h want=1/0000bbaa", o_out_valid, o_out_data); end
    total++; if (o_out_bytes !== 3'd2)         begin bad++; $display("FAIL flush_bytes got=%0d want=2", o_out_bytes); end
    total++; if (o_flush_pending !== 1'b0)     begin bad++; $display("FAIL flush_pend got=%b want=0", o_flush_pending); end
    @(negedge clk);
    i_flush = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_flush_blocked();
    logic [CW-1:0] wc;
    @(negedge clk);
    i_out_ready = 1'b0;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    fifo_q.push_back(8'h44); fifo_q.push_back(8'hEE);
    repeat (8) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk); #1;
    total++; if (o_flush_pending !== 1'b1)     begin bad++; $display("FAIL fb_set got=%b want=1", o_flush_pending); end
    @(negedge clk);
    i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (o_flush_pending !== 1'b1 || o_out_data !== 32'h44332211)
      begin bad++; $display("FAIL fb_hold got=%b/%h want=1/44332211", o_flush_pending, o_out_data); end
    @(negedge clk);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b1 || o_out_data !== 32'h000000EE || o_out_bytes !== 3'd1)
      begin bad++; $display("FAIL fb_emit got=%b/%h/%0d want=1/000000ee/1", o_out_valid, o_out_data, o_out_bytes); end
    total++; if (o_flush_pending !== 1'b0)     begin bad++; $display("FAIL fb_clear got=%b want=0", o_flush_pending); end
    @(posedge clk); #1;
    wc = o_word_count;
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b0 || o_flush_pending !== 1'b0)
      begin bad++; $display("FAIL fb_empty got=%b/%b want=0/0", o_out_valid, o_flush_pending); end
    @(negedge clk);
    i_flush = 1'b0;
    @(posedge clk); #1;
    total++; if (o_word_count !== wc || o_out_valid !== 1'b0)
      begin bad++; $display("FAIL fb_noword got=%0d/%b want=%0d/0", o_word_count, o_out_valid, wc); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    i_out_ready = 1'b1;
    for (int k = 0; k < 24; k++) fifo_q.push_back(8'($urandom));
    for (int k = 0; k < 26; k++) begin
      @(negedge clk); #3;
      if (!i_fifo_empty) begin
        total++;
        if (o_fifo_read_increment !== 1'b1) begin bad++; $display("FAIL stream_bubble got=0 want=1 at=%0d", k); end
      end
    end
    repeat (3) @(negedge clk);
    total++; if (pop_q.size() != 0) begin bad++; $display("FAIL stream_left got=%0d want=0", pop_q.size()); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_out_ready = 1'b0;
    for (int k = 0; k < 7; k++) fifo_q.push_back(8'hB1 + 8'(k));
    repeat (9) @(posedge clk);
    @(negedge clk); #3;
    rst = 1'b1;
    fifo_q.delete(); pop_q.delete(); xfers = 0;
    #1;
    total++; if (o_out_valid !== 1'b0 || o_out_data !== '0 || o_out_bytes !== '0)
      begin bad++; $display("FAIL rmid_out got=%b/%h/%0d want=0/0/0", o_out_valid, o_out_data, o_out_bytes); end
    total++; if (o_word_count !== '0 || o_flush_pending !== 1'b0)
      begin bad++; $display("FAIL rmid_state got=%0d/%b want=0/0", o_word_count, o_flush_pending); end
    @(negedge clk);
    rst = 1'b0;
    i_out_ready = 1'b1;
    fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2); fifo_q.push_back(8'hC3); fifo_q.push_back(8'hC4);
    repeat (4) @(posedge clk);
    #1;
    total++; if (o_out_valid !== 1'b1 || o_out_data !== 32'hC4C3C2C1 || o_out_bytes !== 3'd4)
      begin bad++; $display("FAIL rmid_word got=%b/%h/%0d want=1/c4c3c2c1/4", o_out_valid, o_out_data, o_out_bytes); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    int guard;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      total++;
      if (o_word_count !== CW'(xfers)) begin bad++; $display("FAIL rnd_wc got=%0d want=%0d", o_word_count, xfers); end
      i_out_ready = ($urandom_range(0, 3) != 0);
      i_flush     = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 6) fifo_q.push_back(8'($urandom));
    end
    @(negedge clk);
    i_flush = 1'b0;
    i_out_ready = 1'b1;
    guard = 0;
    while (fifo_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total++; if (fifo_q.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d want=0", fifo_q.size()); end
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pop_q.size() != 0 || o_out_valid !== 1'b0)
      begin bad++; $display("FAIL rnd_flushout got=%0d/%b want=0/0", pop_q.size(), o_out_valid); end
    total++; if (o_word_count !== CW'(xfers) || o_flush_pending !== 1'b0)
      begin bad++; $display("FAIL rnd_final got=%0d/%b want=%0d/0", o_word_count, o_flush_pending, xfers); end
  endtask

  initial begin
    rst = 1'b1;
    i_fifo_empty = 1'b1;
    i_fifo_read_data = '0;
    i_flush = 1'b0;
    i_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_flush_blocked();
    test_stream();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
